safe_lock_ctrl: RTL and testbench

Attempt controller for the digital safe lock. Accepts a parallel code word from the keypad front-end and serialises it MSB-first into the serial unlock checker. It reads the checker's Moore verdict, then drives the unlock solenoid for a bounded time. It also counts consecutive failed attempts and enforces a timed lockout, and sits between the keypad interface and the checker.

---
 rtl/safe_lock_ctrl.sv | 135 +++++++++++++
 tb/tb_safe_lock_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/safe_lock_ctrl.sv
// rtl/safe_lock_ctrl.sv - safe lock attempt controller: code serialiser, verdict, unlock and lockout timing
module safe_lock_ctrl #(
    parameter  int CODE_W         = 4,
    parameter  int MAX_FAILS      = 3,
    parameter  int UNLOCK_CYCLES  = 500,
    parameter  int LOCKOUT_CYCLES = 1000,
    localparam int FC_W           = $clog2(MAX_FAILS + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic              code_ready,
    input  logic              relock,
    output logic              ser_val,
    output logic              ser_data,
    output logic              chk_clr_n,
    input  logic              chk_val,
    input  logic              chk_unlock,
    output logic              unlock,
    output logic              locked_out,
    output logic [FC_W-1:0]   fail_cnt,
    output logic              attempt_done,
    output logic              attempt_pass
);

    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int BC_W    = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SEND    = 3'd2,
        EVAL    = 3'd3,
        OPEN    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] shift;
    logic [BC_W-1:0]   bit_cnt;
    logic [TMR_W-1:0]  timer;
    logic              pass_q;
    logic              take;
    logic              pass;
    logic              last_fail;

    assign take      = code_valid && (state == IDLE);
    assign pass      = chk_val && chk_unlock;
    assign last_fail = (int'(fail_cnt) + 1 == MAX_FAILS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = CLEAR;
            CLEAR:   state_nxt = SEND;
            SEND:    if (bit_cnt == BC_W'(CODE_W - 1)) state_nxt = EVAL;
            EVAL: begin
                if (pass)           state_nxt = OPEN;
                else if (last_fail) state_nxt = LOCKOUT;
                else                state_nxt = IDLE;
            end
            OPEN:    if (timer == '0 || relock) state_nxt = IDLE;
            LOCKOUT: if (timer == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        code_ready   = (state == IDLE);
        unlock       = (state == OPEN);
        locked_out   = (state == LOCKOUT);
        attempt_done = (state == EVAL);
        attempt_pass = (state == EVAL) ? pass : pass_q;
    end

    // Serial outputs are registered from the next state so the checker sees clean flop outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift     <= '0;
            bit_cnt   <= '0;
            ser_val   <= 1'b0;
            ser_data  <= 1'b0;
            chk_clr_n <= 1'b1;
            timer     <= '0;
            fail_cnt  <= '0;
            pass_q    <= 1'b0;
        end else begin
            chk_clr_n <= (state_nxt != CLEAR);
            ser_val   <= (state_nxt == SEND);
            if (take) begin
                shift <= code;
            end else if (state_nxt == SEND) begin
                shift <= shift << 1;
            end
            ser_data <= (state_nxt == SEND) ? shift[CODE_W-1] : 1'b0;

            if (state == CLEAR) begin
                bit_cnt <= '0;
            end else if (state == SEND) begin
                bit_cnt <= bit_cnt + BC_W'(1);
            end

            if (state == EVAL) begin
                pass_q <= pass;
                if (pass) begin
                    fail_cnt <= '0;
                    timer    <= TMR_W'(UNLOCK_CYCLES - 1);
                end else if (last_fail) begin
                    fail_cnt <= FC_W'(MAX_FAILS);
                    timer    <= TMR_W'(LOCKOUT_CYCLES - 1);
                end else begin
                    fail_cnt <= fail_cnt + FC_W'(1);
                end
            end else if (state == OPEN || state == LOCKOUT) begin
                if (timer != '0) begin
                    timer <= timer - TMR_W'(1);
                end else if (state == LOCKOUT) begin
                    fail_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// tb/tb_safe_lock_ctrl.sv - directed bench for safe_lock_ctrl with a behavioural serial checker
module tb_safe_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [3:0] code = 4'b0000;
    logic       relock = 1'b0;
    logic       code_ready, ser_val, ser_data, chk_clr_n, chk_val, chk_unlock;
    logic       unlock, locked_out, attempt_done, attempt_pass;
    logic [1:0] fail_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    safe_lock_ctrl #(
        .CODE_W(4), .MAX_FAILS(3), .UNLOCK_CYCLES(500), .LOCKOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rstn(rst_n), .code_valid(code_valid), .code(code),
        .code_ready(code_ready), .relock(relock), .ser_val(ser_val),
        .ser_data(ser_data), .chk_clr_n(chk_clr_n), .chk_val(chk_val),
        .chk_unlock(chk_unlock), .unlock(unlock), .locked_out(locked_out),
        .fail_cnt(fail_cnt), .attempt_done(attempt_done), .attempt_pass(attempt_pass)
    );

    always #5 clk = ~clk;

    // Serial checker stand-in: Moore verdict after four bits, secret code 1011.
    logic       chk_rstn;
    logic [3:0] chk_sh;
    logic [2:0] chk_n;
    assign chk_rstn = rst_n & chk_clr_n;
    always @(posedge clk or negedge chk_rstn) begin
        if (!chk_rstn) begin
            chk_sh <= 4'b0000;
            chk_n  <= 3'd0;
        end else if (ser_val && chk_n != 3'd4) begin
            chk_sh <= {chk_sh[2:0], ser_data};
            chk_n  <= chk_n + 3'd1;
        end
    end
    assign chk_val    = (chk_n == 3'd4);
    assign chk_unlock = chk_val && (chk_sh == 4'b1011);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_code_ready"}, code_ready, 1);
        check({tag, "_ser_val"}, ser_val, 0);
        check({tag, "_ser_data"}, ser_data, 0);
        check({tag, "_chk_clr_n"}, chk_clr_n, 1);
        check({tag, "_unlock"}, unlock, 0);
        check({tag, "_locked_out"}, locked_out, 0);
        check({tag, "_fail_cnt"}, fail_cnt, 0);
        check({tag, "_attempt_done"}, attempt_done, 0);
        check({tag, "_attempt_pass"}, attempt_pass, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!code_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!code_ready) check("ready_timeout", code_ready, 1);
    endtask

    // Starts and ends on a falling edge; returns in the first cycle after EVAL.
    task automatic attempt(input logic [3:0] c, input logic exp_pass, input string tag);
        wait_ready();
        code       = c;
        code_valid = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0;
        @(negedge clk);
        check({tag, "_clr_low"}, chk_clr_n, 0);
        check({tag, "_ready_busy"}, code_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, "_clr_high"}, chk_clr_n, 1);
            check({tag, "_ser_val"}, ser_val, 1);
            check({tag, "_ser_bit"}, ser_data, c[3-i]);
        end
        @(negedge clk);
        check({tag, "_done"}, attempt_done, 1);
        check({tag, "_pass"}, attempt_pass, exp_pass);
        check({tag, "_eval_ser_val"}, ser_val, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, attempt_done, 0);
        check({tag, "_unlock"}, unlock, exp_pass);
    endtask

    task automatic relock_now(input string tag);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        check({tag, "_unlock_off"}, unlock, 0);
        check({tag, "_ready"}, code_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Correct code, full unlock window
        attempt(4'b1011, 1'b1, "t1");
        check("t1_fail_cnt", fail_cnt, 0);
        n = 0;
        while (unlock && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("t1_unlock_cycles", n, 500);
        check("t1_ready_after", code_ready, 1);

        // Wrong code, then correct code
        attempt(4'b1001, 1'b0, "t2a");
        check("t2a_fail_cnt", fail_cnt, 1);
        check("t2a_ready", code_ready, 1);
        check("t2a_pass_held", attempt_pass, 0);
        attempt(4'b1011, 1'b1, "t2b");
        check("t2b_fail_cnt", fail_cnt, 0);
        check("t2b_pass_held", attempt_pass, 1);
        relock_now("t2b");

        // Three wrong codes lead to lockout
        attempt(4'b0000, 1'b0, "t3a");
        check("t3a_fail_cnt", fail_cnt, 1);
        attempt(4'b1111, 1'b0, "t3b");
        check("t3b_fail_cnt", fail_cnt, 2);
        attempt(4'b1010, 1'b0, "t3c");
        check("t3c_fail_cnt", fail_cnt, 3);
        check("t3c_locked", locked_out, 1);
        code       = 4'b1011;
        code_valid = 1'b1;
        n          = 0;
        viol       = 0;
        while (locked_out && n < 3000) begin
            n++;
            if (code_ready || ser_val || !chk_clr_n) viol++;
            @(negedge clk);
        end
        check("t3_lockout_cycles", n, 1000);
        check("t3_lockout_ignored", viol, 0);
        check("t3_fail_cnt_after", fail_cnt, 0);
        check("t3_ready_after", code_ready, 1);
        code_valid = 1'b0;
        @(negedge clk);

        // Early relock on the 10th open cycle
        attempt(4'b1011, 1'b1, "t4");
        repeat (9) @(negedge clk);
        check("t4_open10", unlock, 1);
        relock_now("t4");

        // Reset during the second serial bit
        attempt(4'b1001, 1'b0, "t5a");
        check("t5a_fail_cnt", fail_cnt, 1);
        wait_ready();
        code       = 4'b1011;
        code_valid = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_in_send", ser_val, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        attempt(4'b1011, 1'b1, "t5b");
        relock_now("t5b");

        // Success clears the failure history
        attempt(4'b0000, 1'b0, "t6a");
        check("t6a_fail_cnt", fail_cnt, 1);
        attempt(4'b0001, 1'b0, "t6b");
        check("t6b_fail_cnt", fail_cnt, 2);
        attempt(4'b1011, 1'b1, "t6c");
        check("t6c_fail_cnt", fail_cnt, 0);
        relock_now("t6c");
        attempt(4'b0000, 1'b0, "t6d");
        check("t6d_fail_cnt", fail_cnt, 1);
        check("t6d_locked", locked_out, 0);
        attempt(4'b0100, 1'b0, "t6e");
        check("t6e_fail_cnt", fail_cnt, 2);
        check("t6e_locked", locked_out, 0);
        attempt(4'b0110, 1'b0, "t6f");
        check("t6f_fail_cnt", fail_cnt, 3);
        check("t6f_locked", locked_out, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
